// File: rtl/burst_frame_extractor_if.sv
// Word-stream bundle between the burst synchronizer/scheduler side and the
// burst frame extractor, plus the framed payload and status returned to the MAC.
interface burst_frame_extractor_if;
  logic [31:0] in_data;
  logic        in_detected;
  logic        in_window;
  logic        out_sync_enable;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  out_onu_id;
  logic        out_error;
  logic [1:0]  out_error_code;
  logic [15:0] out_burst_count;
  logic [15:0] out_error_count;

  // Upstream/sink side: drives the aligned stream, observes the framed output.
  modport master (
    output in_data, in_detected, in_window,
    input  out_sync_enable, out_data, out_valid, out_sop, out_eop, out_onu_id,
           out_error, out_error_code, out_burst_count, out_error_count
  );

  // Extractor side.
  modport slave (
    input  in_data, in_detected, in_window,
    output out_sync_enable, out_data, out_valid, out_sop, out_eop, out_onu_id,
           out_error, out_error_code, out_burst_count, out_error_count
  );
endinterface

// File: rtl/burst_frame_extractor.sv
// Locks onto one PON upstream burst per window, validates its header and
// emits the payload as a framed word stream; gates synchronizer re-training.
module burst_frame_extractor #(
  parameter int unsigned HDR_OFFSET   = 1,
  parameter int unsigned MAX_WORDS    = 1024,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                    in_clock,
  input  logic                    in_reset_n,
  burst_frame_extractor_if.slave  bus
);

  localparam int unsigned OFF_W = 4;
  localparam int unsigned GRD_W = 8;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned CMP_W = LEN_W + 1;

  localparam logic [OFF_W-1:0] OFF_LOAD = OFF_W'(HDR_OFFSET - 1);
  localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD_CYCLES - 1);
  localparam logic [CMP_W-1:0] MAX_LEN  = CMP_W'(MAX_WORDS);

  localparam logic [1:0] ERR_CHECK = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_TRUNC = 2'b11;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_WAIT,
    ST_HEADER,
    ST_PAYLOAD,
    ST_GUARD
  } state_e;

  typedef struct packed {
    logic [7:0]       onu_id;
    logic [7:0]       onu_chk;
    logic [LEN_W-1:0] len;
  } hdr_t;

  state_e           state_q, state_d;
  logic [OFF_W-1:0] off_q;
  logic [GRD_W-1:0] grd_q;
  logic [LEN_W-1:0] rem_q;
  logic             first_q;

  logic             err_c;
  logic [1:0]       err_code_c;
  logic             win;
  hdr_t             hdr;

  logic             sync_enable_q;
  logic [31:0]      data_q;
  logic             valid_q;
  logic             sop_q;
  logic             eop_q;
  logic [7:0]       onu_id_q;
  logic             error_q;
  logic [1:0]       error_code_q;
  logic [15:0]      burst_count_q;
  logic [15:0]      error_count_q;

  assign win = bus.in_window;
  assign hdr = hdr_t'(bus.in_data);

  // Next state and error detection.
  always_comb begin
    state_d    = state_q;
    err_c      = 1'b0;
    err_code_c = ERR_CHECK;
    case (state_q)
      ST_HUNT: begin
        if (bus.in_detected && win) begin
          state_d = (HDR_OFFSET == 32'd1) ? ST_HEADER : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!win) begin
          state_d    = ST_GUARD;
          err_c      = 1'b1;
          err_code_c = ERR_TRUNC;
        end else if (off_q == OFF_W'(1)) begin
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        state_d = ST_GUARD;
        err_c   = 1'b1;
        if (!win) begin
          err_code_c = ERR_TRUNC;
        end else if (hdr.onu_chk != ~hdr.onu_id) begin
          err_code_c = ERR_CHECK;
        end else if ((hdr.len == '0) || ({1'b0, hdr.len} > MAX_LEN)) begin
          err_code_c = ERR_LEN;
        end else begin
          state_d = ST_PAYLOAD;
          err_c   = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (!win) begin
          state_d    = ST_GUARD;
          err_c      = 1'b1;
          err_code_c = ERR_TRUNC;
        end else if (rem_q == LEN_W'(1)) begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (grd_q == '0) begin
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q       <= ST_HUNT;
      off_q         <= '0;
      grd_q         <= '0;
      rem_q         <= '0;
      first_q       <= 1'b0;
      sync_enable_q <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      onu_id_q      <= '0;
      error_q       <= 1'b0;
      error_code_q  <= '0;
      burst_count_q <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sync_enable_q <= (state_d == ST_HUNT) && win;
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      error_q       <= err_c;

      if (err_c) begin
        error_code_q <= err_code_c;
        if (error_count_q != 16'hFFFF) begin
          error_count_q <= error_count_q + 16'd1;
        end
      end

      case (state_q)
        ST_HUNT: off_q <= OFF_LOAD;
        ST_WAIT: off_q <= off_q - OFF_W'(1);
        ST_HEADER: begin
          if (state_d == ST_PAYLOAD) begin
            onu_id_q <= hdr.onu_id;
            rem_q    <= hdr.len;
            first_q  <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          // A word arriving with the window dropped is discarded.
          if (win) begin
            data_q  <= bus.in_data;
            valid_q <= 1'b1;
            sop_q   <= first_q;
            eop_q   <= (rem_q == LEN_W'(1));
            first_q <= 1'b0;
            rem_q   <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              burst_count_q <= burst_count_q + 16'd1;
            end
          end
        end
        ST_GUARD: grd_q <= grd_q - GRD_W'(1);
        default: ;
      endcase

      if ((state_d == ST_GUARD) && (state_q != ST_GUARD)) begin
        grd_q <= GRD_LOAD;
      end
    end
  end

  assign bus.out_sync_enable = sync_enable_q;
  assign bus.out_data        = data_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_sop         = sop_q;
  assign bus.out_eop         = eop_q;
  assign bus.out_onu_id      = onu_id_q;
  assign bus.out_error       = error_q;
  assign bus.out_error_code  = error_code_q;
  assign bus.out_burst_count = burst_count_q;
  assign bus.out_error_count = error_count_q;

endmodule

// File: tb/tb_burst_frame_extractor.sv
// Directed self-checking bench: a default instance (offset 1, guard 4) and a
// second instance (offset 3, guard 2, max 16 words) sharing the same stimulus.
module tb_burst_frame_extractor;

  logic in_clock = 1'b0;
  logic in_reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  burst_frame_extractor_if bus ();
  burst_frame_extractor_if bus3 ();

  burst_frame_extractor dut (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .bus        (bus)
  );

  burst_frame_extractor #(
    .HDR_OFFSET   (3),
    .MAX_WORDS    (16),
    .GUARD_CYCLES (2)
  ) dut3 (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .bus        (bus3)
  );

  assign bus3.in_data     = bus.in_data;
  assign bus3.in_detected = bus.in_detected;
  assign bus3.in_window   = bus.in_window;

  always #5 in_clock = ~in_clock;

  task automatic tick();
    @(posedge in_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".sync"},  32'(bus.out_sync_enable), 32'd0);
    chk({tag, ".data"},  bus.out_data,             32'd0);
    chk({tag, ".valid"}, 32'(bus.out_valid),       32'd0);
    chk({tag, ".sop"},   32'(bus.out_sop),         32'd0);
    chk({tag, ".eop"},   32'(bus.out_eop),         32'd0);
    chk({tag, ".onu"},   32'(bus.out_onu_id),      32'd0);
    chk({tag, ".err"},   32'(bus.out_error),       32'd0);
    chk({tag, ".code"},  32'(bus.out_error_code),  32'd0);
    chk({tag, ".bcnt"},  32'(bus.out_burst_count), 32'd0);
    chk({tag, ".ecnt"},  32'(bus.out_error_count), 32'd0);
  endtask

  // Detect in HUNT, then present the header word on the next cycle (offset 1).
  task automatic send_hdr(input string tag, input logic [31:0] hdr);
    bus.in_detected = 1'b1;
    tick();
    chk({tag, ".sync_off"}, 32'(bus.out_sync_enable), 32'd0);
    bus.in_detected = 1'b0;
    bus.in_data     = hdr;
    tick();
  endtask

  // Feed n payload words of a burst of length len; detect pulsed on word 1.
  task automatic send_words(input string tag, input int n, input int len, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      bus.in_data     = base + 32'(k);
      bus.in_detected = (k == 1);
      tick();
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".data"},  bus.out_data,       base + 32'(k));
      chk({tag, ".sop"},   32'(bus.out_sop),   32'(k == 0));
      chk({tag, ".eop"},   32'(bus.out_eop),   32'(k == len - 1));
    end
    bus.in_detected = 1'b0;
  endtask

  // Guard already entered on the previous edge; HUNT returns after 4 cycles.
  task automatic guard_wait(input string tag, input int det_at);
    for (int i = 0; i < 3; i++) begin
      bus.in_detected = (i == det_at);
      tick();
      chk({tag, ".g_sync"},  32'(bus.out_sync_enable), 32'd0);
      chk({tag, ".g_valid"}, 32'(bus.out_valid),       32'd0);
      chk({tag, ".g_err"},   32'(bus.out_error),       32'd0);
    end
    bus.in_detected = 1'b0;
    tick();
    chk({tag, ".hunt_sync"}, 32'(bus.out_sync_enable), 32'd1);
  endtask

  initial begin
    in_reset_n      = 1'b0;
    bus.in_data     = '0;
    bus.in_detected = 1'b0;
    bus.in_window   = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    in_reset_n    = 1'b1;
    bus.in_window = 1'b1;
    tick();
    chk("hunt_sync", 32'(bus.out_sync_enable), 32'd1);

    // Good burst, L = 3, with a detection pulse inside the guard.
    send_hdr("good", 32'h2AD5_0003);
    chk("good.hdr_valid", 32'(bus.out_valid), 32'd0);
    chk("good.onu", 32'(bus.out_onu_id), 32'h2A);
    send_words("good", 3, 3, 32'hA000_0000);
    chk("good.bcnt", 32'(bus.out_burst_count), 32'd1);
    chk("good.sync_eop", 32'(bus.out_sync_enable), 32'd0);
    guard_wait("good", 1);

    // Header check failure keeps the previous ONU id.
    send_hdr("chk", 32'h3C3C_0003);
    chk("chk.err",   32'(bus.out_error),       32'd1);
    chk("chk.code",  32'(bus.out_error_code),  32'd1);
    chk("chk.ecnt",  32'(bus.out_error_count), 32'd1);
    chk("chk.valid", 32'(bus.out_valid),       32'd0);
    chk("chk.onu",   32'(bus.out_onu_id),      32'h2A);
    guard_wait("chk", -1);

    send_hdr("len0", 32'h2AD5_0000);
    chk("len0.err",  32'(bus.out_error),       32'd1);
    chk("len0.code", 32'(bus.out_error_code),  32'd2);
    chk("len0.ecnt", 32'(bus.out_error_count), 32'd2);
    guard_wait("len0", -1);

    send_hdr("len1025", 32'h2AD5_0401);
    chk("len1025.err",  32'(bus.out_error),       32'd1);
    chk("len1025.code", 32'(bus.out_error_code),  32'd2);
    chk("len1025.ecnt", 32'(bus.out_error_count), 32'd3);
    guard_wait("len1025", -1);

    // L = 1: sop and eop together.
    send_hdr("l1", 32'h11EE_0001);
    chk("l1.onu", 32'(bus.out_onu_id), 32'h11);
    send_words("l1", 1, 1, 32'h0000_5A5A);
    chk("l1.bcnt", 32'(bus.out_burst_count), 32'd2);
    guard_wait("l1", -1);

    // L = MAX_WORDS is accepted in full.
    send_hdr("l1024", 32'h7788_0400);
    send_words("l1024", 1024, 1024, 32'h1000_0000);
    chk("l1024.bcnt", 32'(bus.out_burst_count), 32'd3);
    guard_wait("l1024", -1);

    // Window drops after 3 of 8 payload words.
    send_hdr("trunc", 32'h4BB4_0008);
    chk("trunc.onu", 32'(bus.out_onu_id), 32'h4B);
    send_words("trunc", 3, 8, 32'hC000_0000);
    bus.in_window = 1'b0;
    bus.in_data   = 32'hDEAD_BEEF;
    tick();
    chk("trunc.valid", 32'(bus.out_valid),       32'd0);
    chk("trunc.eop",   32'(bus.out_eop),         32'd0);
    chk("trunc.err",   32'(bus.out_error),       32'd1);
    chk("trunc.code",  32'(bus.out_error_code),  32'd3);
    chk("trunc.ecnt",  32'(bus.out_error_count), 32'd4);
    chk("trunc.bcnt",  32'(bus.out_burst_count), 32'd3);
    bus.in_window = 1'b1;
    guard_wait("trunc", -1);

    // Detection with the window low is ignored in HUNT.
    bus.in_window   = 1'b0;
    bus.in_detected = 1'b1;
    tick();
    chk("hunt_lo.sync", 32'(bus.out_sync_enable), 32'd0);
    bus.in_window   = 1'b1;
    bus.in_detected = 1'b0;
    bus.in_data     = 32'h2AD5_0003;
    tick();
    chk("hunt_lo.sync1", 32'(bus.out_sync_enable), 32'd1);
    tick();
    chk("hunt_lo.valid", 32'(bus.out_valid),  32'd0);
    chk("hunt_lo.onu",   32'(bus.out_onu_id), 32'h4B);
    chk("hunt_lo.err",   32'(bus.out_error),  32'd0);

    // Window low on the header cycle is a truncation.
    bus.in_detected = 1'b1;
    tick();
    bus.in_detected = 1'b0;
    bus.in_window   = 1'b0;
    bus.in_data     = 32'h6699_0002;
    tick();
    chk("hdr_lo.err",  32'(bus.out_error),       32'd1);
    chk("hdr_lo.code", 32'(bus.out_error_code),  32'd3);
    chk("hdr_lo.ecnt", 32'(bus.out_error_count), 32'd5);
    chk("hdr_lo.onu",  32'(bus.out_onu_id),      32'h4B);
    bus.in_window = 1'b1;
    guard_wait("hdr_lo", -1);

    // Reset in the middle of a payload clears everything at once.
    send_hdr("rst", 32'h22DD_0004);
    send_words("rst", 2, 4, 32'hE000_0000);
    in_reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick();
    in_reset_n = 1'b1;
    tick();
    send_hdr("post", 32'h33CC_0002);
    chk("post.onu", 32'(bus.out_onu_id), 32'h33);
    send_words("post", 2, 2, 32'hF000_0000);
    chk("post.bcnt", 32'(bus.out_burst_count), 32'd1);
    chk("post.ecnt", 32'(bus.out_error_count), 32'd0);
    guard_wait("post", -1);

    // Offset-3 / guard-2 / max-16 instance.
    in_reset_n = 1'b0;
    tick();
    in_reset_n = 1'b1;
    tick();
    chk("o3.sync", 32'(bus3.out_sync_enable), 32'd1);
    bus.in_detected = 1'b1;
    tick();
    chk("o3.sync_off", 32'(bus3.out_sync_enable), 32'd0);
    bus.in_detected = 1'b0;
    bus.in_data     = 32'h1234_5678;
    tick();
    tick();
    chk("o3.wait_valid", 32'(bus3.out_valid),  32'd0);
    chk("o3.wait_onu",   32'(bus3.out_onu_id), 32'h00);
    bus.in_data = 32'h5AA5_0002;
    tick();
    chk("o3.onu",   32'(bus3.out_onu_id), 32'h5A);
    chk("o3.valid", 32'(bus3.out_valid),  32'd0);
    bus.in_data = 32'hB000_0000;
    tick();
    chk("o3.w0_valid", 32'(bus3.out_valid), 32'd1);
    chk("o3.w0_sop",   32'(bus3.out_sop),   32'd1);
    chk("o3.w0_data",  bus3.out_data,       32'hB000_0000);
    bus.in_data = 32'hB000_0001;
    tick();
    chk("o3.w1_eop",  32'(bus3.out_eop),         32'd1);
    chk("o3.w1_data", bus3.out_data,             32'hB000_0001);
    chk("o3.bcnt",    32'(bus3.out_burst_count), 32'd1);
    tick();
    chk("o3.g_sync", 32'(bus3.out_sync_enable), 32'd0);
    tick();
    chk("o3.hunt_sync", 32'(bus3.out_sync_enable), 32'd1);

    // Window low during WAIT.
    bus.in_detected = 1'b1;
    tick();
    bus.in_detected = 1'b0;
    bus.in_window   = 1'b0;
    tick();
    chk("o3w.err",  32'(bus3.out_error),       32'd1);
    chk("o3w.code", 32'(bus3.out_error_code),  32'd3);
    chk("o3w.ecnt", 32'(bus3.out_error_count), 32'd1);
    bus.in_window = 1'b1;
    tick();
    chk("o3w.g_sync", 32'(bus3.out_sync_enable), 32'd0);
    chk("o3w.g_err",  32'(bus3.out_error),       32'd0);
    tick();
    chk("o3w.hunt_sync", 32'(bus3.out_sync_enable), 32'd1);

    // Length 17 exceeds MAX_WORDS = 16.
    bus.in_detected = 1'b1;
    tick();
    bus.in_detected = 1'b0;
    tick();
    tick();
    bus.in_data = 32'h10EF_0011;
    tick();
    chk("o3l.err",  32'(bus3.out_error),       32'd1);
    chk("o3l.code", 32'(bus3.out_error_code),  32'd2);
    chk("o3l.ecnt", 32'(bus3.out_error_count), 32'd2);
    chk("o3l.onu",  32'(bus3.out_onu_id),      32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
